alu_arbiter: RTL and testbench

- Shares one combinational ALU (32-bit operands, 5-bit shift, 4-bit control, 3-bit flags) between two requesters: requester 0 is the execute stage, requester 1 is the address/branch helper.
- Each request is one operation. It is accepted with a valid/ready handshake and issued to the ALU through registered operand lines. Result and flags are captured and returned on the requester's own response channel.
- Arbitration is round-robin, so neither requester can starve the other.

---
 rtl/alu_arbiter_if.sv | 32 +++
 rtl/alu_arbiter.sv | 57 +++++
 tb/tb_alu_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, response and ALU operand/result bundle for alu_arbiter
interface alu_arbiter_if #(parameter int WIDTH = 32, parameter int SHW = 5);
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [SHW-1:0] req0_shift, req1_shift;
  logic [3:0] req0_cntrl, req1_cntrl;
  logic resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [WIDTH-1:0] resp_result;
  logic [2:0] resp_flag;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [SHW-1:0] alu_shift;
  logic [3:0] alu_cntrl;
  logic [2:0] alu_flag;
  modport master (
    output req0_valid, req0_a, req0_b, req0_shift, req0_cntrl,
    output req1_valid, req1_a, req1_b, req1_shift, req1_cntrl,
    input req0_ready, req1_ready,
    input resp0_valid, resp1_valid, resp_result, resp_flag,
    output resp0_ready, resp1_ready,
    input alu_a, alu_b, alu_shift, alu_cntrl,
    output alu_result, alu_flag
  );
  modport slave (
    input req0_valid, req0_a, req0_b, req0_shift, req0_cntrl,
    input req1_valid, req1_a, req1_b, req1_shift, req1_cntrl,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp_result, resp_flag,
    input resp0_ready, resp1_ready,
    output alu_a, alu_b, alu_shift, alu_cntrl,
    input alu_result, alu_flag
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int SHW = 5
) (
  input logic clk,
  input logic rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic prio, owner, grant, take, done;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [SHW-1:0] shift_sel;
  logic [3:0] cntrl_sel;
  always_comb begin
    grant = bus.req0_valid && bus.req1_valid ? prio : bus.req1_valid;
    take = state == IDLE && (bus.req0_valid || bus.req1_valid);
    done = state == RESP && (owner ? bus.resp1_ready : bus.resp0_ready);
    state_nx = state == IDLE ? (take ? EXEC : IDLE) : state == EXEC ? RESP : (done ? IDLE : RESP);
    a_sel = grant ? bus.req1_a : bus.req0_a;
    b_sel = grant ? bus.req1_b : bus.req0_b;
    shift_sel = grant ? bus.req1_shift : bus.req0_shift;
    cntrl_sel = grant ? bus.req1_cntrl : bus.req0_cntrl;
    bus.req0_ready = take && !grant && bus.req0_valid;
    bus.req1_ready = take && grant && bus.req1_valid;
    bus.resp0_valid = state == RESP && !owner;
    bus.resp1_valid = state == RESP && owner;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio <= 1'b0;
      owner <= 1'b0;
      bus.alu_a <= '0;
      bus.alu_b <= '0;
      bus.alu_shift <= '0;
      bus.alu_cntrl <= '0;
      bus.resp_result <= '0;
      bus.resp_flag <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        owner <= grant;
        bus.alu_a <= a_sel;
        bus.alu_b <= b_sel;
        bus.alu_shift <= shift_sel;
        bus.alu_cntrl <= cntrl_sel;
      end
      if (state == EXEC) begin
        bus.resp_result <= bus.alu_result;
        bus.resp_flag <= bus.alu_flag;
      end
      if (done) prio <= ~owner;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: vector table plus corner-case sequences, scoreboard-checked responses
module tb_alu_arbiter;
  typedef struct {
    bit ch;
    logic [31:0] a, b;
    logic [4:0] sh;
    logic [3:0] c;
    logic [31:0] r;
    logic [2:0] f;
  } vec_t;
  typedef struct {
    bit ch;
    logic [31:0] r;
    logic [2:0] f;
  } exp_t;
  logic clk = 0, rst = 1;
  int total = 0, bad = 0;
  exp_t sbq[$];
  vec_t vt[10];
  logic [32:0] sum;
  alu_arbiter_if #(.WIDTH(32), .SHW(5)) bus ();
  alu_arbiter #(.WIDTH(32), .SHW(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // Reference ALU: zero/sign reflect operand a, carry only from the sum
  always_comb begin
    sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    bus.alu_result = '0;
    case (bus.alu_cntrl)
      4'd0: bus.alu_result = sum[31:0];
      4'd1: bus.alu_result = ~bus.alu_a;
      4'd2: bus.alu_result = bus.alu_a & bus.alu_b;
      4'd3: bus.alu_result = bus.alu_a ^ bus.alu_b;
      4'd4: bus.alu_result = bus.alu_a - bus.alu_b;
      4'd5: bus.alu_result = bus.alu_a >> bus.alu_shift;
      4'd6: bus.alu_result = bus.alu_a << bus.alu_shift;
      4'd7: bus.alu_result = $signed(bus.alu_a) >>> bus.alu_shift;
      default: bus.alu_result = '0;
    endcase
    bus.alu_flag = {bus.alu_a[31], bus.alu_a == 32'd0, bus.alu_cntrl == 4'd0 && sum[32]};
  end
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    chk("ready_excl", bus.req0_ready & bus.req1_ready, 0);
    chk("resp_excl", bus.resp0_valid & bus.resp1_valid, 0);
    if ((bus.resp0_valid && bus.resp0_ready) || (bus.resp1_valid && bus.resp1_ready)) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL resp_unexpected got=ch%0d result=%0h want=none", bus.resp1_valid, bus.resp_result);
      end else begin
        e = sbq.pop_front();
        chk("resp_ch", bus.resp1_valid, e.ch);
        chk("resp_result", bus.resp_result, e.r);
        chk("resp_flag", bus.resp_flag, e.f);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input bit ch, input logic [31:0] a, b, input logic [4:0] sh, input logic [3:0] c, input bit v);
    if (ch) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_shift = sh; bus.req1_cntrl = c; bus.req1_valid = v;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_shift = sh; bus.req0_cntrl = c; bus.req0_valid = v;
    end
  endtask
  task automatic do_reset();
    step();
    rst = 1;
    step();
    rst = 0;
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_resp_valid"}, {bus.resp1_valid, bus.resp0_valid}, 0);
    chk({n, "_resp_result"}, bus.resp_result, 0);
    chk({n, "_resp_flag"}, bus.resp_flag, 0);
    chk({n, "_alu_ops"}, {bus.alu_a, bus.alu_b} , 0);
    chk({n, "_alu_ctl"}, {bus.alu_shift, bus.alu_cntrl}, 0);
  endtask
  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", sbq.size(), 0);
  endtask
  task automatic run_vec(input vec_t v);
    int n = 0;
    step();
    drv(v.ch, v.a, v.b, v.sh, v.c, 1'b1);
    @(negedge clk);
    while (!(v.ch ? bus.req1_ready : bus.req0_ready) && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("accept", n < 10, 1);
    if (n < 10) sbq.push_back('{v.ch, v.r, v.f});
    step();
    drv(v.ch, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd31, 4'hF, 1'b0);
    @(negedge clk);
    chk("exec_quiet", {bus.resp1_valid, bus.resp0_valid}, 0);
    @(negedge clk);
    chk("latency_own", v.ch ? bus.resp1_valid : bus.resp0_valid, 1);
    chk("latency_other", v.ch ? bus.resp0_valid : bus.resp1_valid, 0);
    step();
  endtask
  initial begin
    int g[$];
    int n;
    vt[0] = '{0, 32'd5, 32'd7, 5'd0, 4'd0, 32'd12, 3'b000};
    vt[1] = '{1, 32'hFFFF_FFFF, 32'd1, 5'd0, 4'd0, 32'd0, 3'b101};
    vt[2] = '{0, 32'd0, 32'd0, 5'd0, 4'd9, 32'd0, 3'b010};
    vt[3] = '{0, 32'd8, 32'd0, 5'd2, 4'd5, 32'd2, 3'b000};
    vt[4] = '{1, 32'd8, 32'd0, 5'd2, 4'd6, 32'd32, 3'b000};
    vt[5] = '{0, 32'hF0F0_0000, 32'h0FF0_0000, 5'd0, 4'd2, 32'h00F0_0000, 3'b100};
    vt[6] = '{1, 32'd12, 32'd5, 5'd0, 4'd4, 32'd7, 3'b000};
    vt[7] = '{0, 32'h8000_0000, 32'd0, 5'd4, 4'd7, 32'hF800_0000, 3'b100};
    vt[8] = '{1, 32'h1234, 32'h1234, 5'd0, 4'd3, 32'd0, 3'b000};
    vt[9] = '{0, 32'h0000_FFFF, 32'd0, 5'd0, 4'd1, 32'hFFFF_0000, 3'b000};
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    bus.resp0_ready = 1;
    bus.resp1_ready = 1;
    step();
    step();
    rst = 0;
    @(negedge clk);
    chk_zero("reset");
    chk("reset_ready", {bus.req1_ready, bus.req0_ready}, 0);
    for (int i = 0; i < 10; i++) run_vec(vt[i]);
    drain();
    // Both requesters always valid: grants must alternate starting with 0
    do_reset();
    drv(0, 32'd8, 0, 5'd2, 4'd5, 1'b1);
    drv(1, 32'd8, 0, 5'd2, 4'd6, 1'b1);
    n = 0;
    while (g.size() < 4 && n < 50) begin
      @(negedge clk);
      n++;
      if (bus.req0_ready) begin g.push_back(0); sbq.push_back('{0, 32'd2, 3'b000}); end
      if (bus.req1_ready) begin g.push_back(1); sbq.push_back('{1, 32'd32, 3'b000}); end
    end
    chk("alt_count", g.size(), 4);
    foreach (g[i]) chk("alt_grant", g[i], i % 2);
    step();
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    drain();
    // Response back-pressure on requester 0
    do_reset();
    bus.resp0_ready = 0;
    drv(0, 32'd3, 32'd4, 0, 4'd0, 1'b1);
    @(negedge clk);
    chk("bp_accept", bus.req0_ready, 1);
    sbq.push_back('{0, 32'd7, 3'b000});
    step();
    drv(0, 32'd1, 32'd1, 0, 4'd0, 1'b1);
    drv(1, 32'd6, 32'd0, 0, 4'd0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", {bus.resp1_valid, bus.resp0_valid}, 2'b01);
      chk("bp_result", bus.resp_result, 32'd7);
      chk("bp_flag", bus.resp_flag, 0);
      chk("bp_ready", {bus.req1_ready, bus.req0_ready}, 0);
      if (k < 4) @(negedge clk);
    end
    step();
    bus.resp0_ready = 1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("bp_next_grant", {bus.req1_ready, bus.req0_ready}, 2'b10);
    if (bus.req1_ready) sbq.push_back('{1, 32'd6, 3'b000});
    step();
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    drain();
    // Reset while in EXEC discards the operation
    do_reset();
    drv(0, 32'd5, 32'd7, 0, 4'd0, 1'b1);
    @(negedge clk);
    chk("rx_accept", bus.req0_ready, 1);
    step();
    drv(0, 0, 0, 0, 0, 0);
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk_zero("rst_exec");
    repeat (4) @(negedge clk);
    chk("rst_exec_quiet", {bus.resp1_valid, bus.resp0_valid}, 0);
    // Reset while in RESP, then simultaneous requests must favour requester 0
    bus.resp1_ready = 0;
    step();
    drv(1, 32'hFFFF_FFFF, 32'd1, 0, 4'd0, 1'b1);
    @(negedge clk);
    chk("rr_accept", bus.req1_ready, 1);
    step();
    drv(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rr_in_resp", bus.resp1_valid, 1);
    step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk_zero("rst_resp");
    bus.resp1_ready = 1;
    step();
    drv(0, 32'd5, 32'd7, 0, 4'd0, 1'b1);
    drv(1, 32'd8, 0, 5'd2, 4'd6, 1'b1);
    @(negedge clk);
    chk("rr_prio0", {bus.req1_ready, bus.req0_ready}, 2'b01);
    if (bus.req0_ready) sbq.push_back('{0, 32'd12, 3'b000});
    step();
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    drain();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
